// File: rtl/hsid_x_ctrl_seq.sv
// HSID-X control sequencer: runs one job as a fixed register-bus sequence
// (clear, configure, start, poll, read MSE) and returns results plus status.
package hsid_x_reg_pkg;
  localparam int HSID_WORD_WIDTH        = 32;
  localparam int HSID_HSP_BANDS_WIDTH   = 12;
  localparam int HSID_HSP_LIBRARY_WIDTH = 8;
  localparam int REG_ADDR_WIDTH         = 8;

  typedef struct packed {
    logic                          valid;
    logic                          write;
    logic [REG_ADDR_WIDTH-1:0]     addr;
    logic [HSID_WORD_WIDTH-1:0]    wdata;
    logic [HSID_WORD_WIDTH/8-1:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic                       ready;
    logic [HSID_WORD_WIDTH-1:0] rdata;
    logic                       error;
  } reg_rsp_t;
endpackage

package hsid_x_ctrl_reg_pkg;
  localparam logic [7:0] STATUS_OFFSET              = 8'h00;
  localparam logic [7:0] LIBRARY_SIZE_OFFSET        = 8'h04;
  localparam logic [7:0] PIXEL_BANDS_OFFSET         = 8'h08;
  localparam logic [7:0] CAPTURED_PIXEL_ADDR_OFFSET = 8'h0C;
  localparam logic [7:0] LIBRARY_PIXEL_ADDR_OFFSET  = 8'h10;
  localparam logic [7:0] MSE_MIN_REF_OFFSET         = 8'h14;
  localparam logic [7:0] MSE_MAX_REF_OFFSET         = 8'h18;
  localparam logic [7:0] MSE_MIN_VALUE_OFFSET       = 8'h1C;
  localparam logic [7:0] MSE_MAX_VALUE_OFFSET       = 8'h20;
endpackage

module hsid_x_ctrl_seq
  import hsid_x_reg_pkg::*;
  import hsid_x_ctrl_reg_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
  parameter int POLL_GAP          = 4,
  parameter int MAX_POLLS         = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [HSP_LIBRARY_WIDTH-1:0] cmd_library_size,
  input  logic [HSP_BANDS_WIDTH-1:0]   cmd_pixel_bands,
  input  logic [WORD_WIDTH-1:0]        cmd_captured_pixel_addr,
  input  logic [WORD_WIDTH-1:0]        cmd_library_pixel_addr,
  output reg_req_t                     reg_req,
  input  reg_rsp_t                     reg_rsp,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [HSP_LIBRARY_WIDTH-1:0] res_mse_min_ref,
  output logic [WORD_WIDTH-1:0]        res_mse_min_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] res_mse_max_ref,
  output logic [WORD_WIDTH-1:0]        res_mse_max_value,
  output logic [2:0]                   res_status,
  output logic                         busy
);
  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [3:0] {
    IDLE, WR_CLEAR, WR_LIB, WR_BANDS, WR_CAP, WR_LADDR, WR_START,
    POLL_RD, POLL_WAIT, RD_MAX_REF, RD_MAX_VAL, RD_MIN_REF, RD_MIN_VAL,
    WR_ABORT, RESP
  } state_t;

  state_t                       state, state_n;
  logic [PW-1:0]                poll_cnt;
  logic [PW-1:0]                poll_inc;
  logic [GW-1:0]                gap_cnt;
  logic [HSP_LIBRARY_WIDTH-1:0] job_lib;
  logic [HSP_BANDS_WIDTH-1:0]   job_bands;
  logic [WORD_WIDTH-1:0]        job_cap;
  logic [WORD_WIDTH-1:0]        job_laddr;
  logic                         xfer, bus_st, wr_sel;
  logic [REG_ADDR_WIDTH-1:0]    addr_sel;
  logic [WORD_WIDTH-1:0]        wdata_sel;

  assign xfer      = reg_req.valid && reg_rsp.ready;
  assign poll_inc  = poll_cnt + PW'(1);
  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign res_valid = (state == RESP);

  always_comb begin
    state_n   = state;
    bus_st    = 1'b1;
    wr_sel    = 1'b1;
    addr_sel  = STATUS_OFFSET;
    wdata_sel = '0;
    case (state)
      IDLE: begin
        bus_st = 1'b0;
        if (cmd_valid && cmd_ready) state_n = WR_CLEAR;
      end
      WR_CLEAR: begin
        wdata_sel = WORD_WIDTH'(8'h10);
        if (xfer) state_n = WR_LIB;
      end
      WR_LIB: begin
        addr_sel  = LIBRARY_SIZE_OFFSET;
        wdata_sel = WORD_WIDTH'(job_lib);
        if (xfer) state_n = WR_BANDS;
      end
      WR_BANDS: begin
        addr_sel  = PIXEL_BANDS_OFFSET;
        wdata_sel = WORD_WIDTH'(job_bands);
        if (xfer) state_n = WR_CAP;
      end
      WR_CAP: begin
        addr_sel  = CAPTURED_PIXEL_ADDR_OFFSET;
        wdata_sel = job_cap;
        if (xfer) state_n = WR_LADDR;
      end
      WR_LADDR: begin
        addr_sel  = LIBRARY_PIXEL_ADDR_OFFSET;
        wdata_sel = job_laddr;
        if (xfer) state_n = WR_START;
      end
      WR_START: begin
        wdata_sel = WORD_WIDTH'(8'h01);
        if (xfer) state_n = POLL_RD;
      end
      POLL_RD: begin
        wr_sel = 1'b0;
        if (xfer) begin
          if (reg_rsp.rdata[5] || reg_rsp.rdata[3]) state_n = RD_MAX_REF;
          else if (poll_inc == PW'(MAX_POLLS))      state_n = WR_ABORT;
          else                                      state_n = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        bus_st = 1'b0;
        if (gap_cnt == GW'(POLL_GAP - 1)) state_n = POLL_RD;
      end
      RD_MAX_REF: begin
        wr_sel   = 1'b0;
        addr_sel = MSE_MAX_REF_OFFSET;
        if (xfer) state_n = RD_MAX_VAL;
      end
      RD_MAX_VAL: begin
        wr_sel   = 1'b0;
        addr_sel = MSE_MAX_VALUE_OFFSET;
        if (xfer) state_n = RD_MIN_REF;
      end
      RD_MIN_REF: begin
        wr_sel   = 1'b0;
        addr_sel = MSE_MIN_REF_OFFSET;
        if (xfer) state_n = RD_MIN_VAL;
      end
      RD_MIN_VAL: begin
        wr_sel   = 1'b0;
        addr_sel = MSE_MIN_VALUE_OFFSET;
        if (xfer) state_n = RESP;
      end
      WR_ABORT: begin
        wdata_sel = WORD_WIDTH'(8'h10);
        if (xfer) state_n = RESP;
      end
      RESP: begin
        bus_st = 1'b0;
        if (res_ready) state_n = IDLE;
      end
      default: begin
        bus_st  = 1'b0;
        state_n = IDLE;
      end
    endcase
    // a failed bus access ends the job without further traffic
    if (xfer && reg_rsp.error) state_n = RESP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      reg_req           <= '0;
      poll_cnt          <= '0;
      gap_cnt           <= '0;
      job_lib           <= '0;
      job_bands         <= '0;
      job_cap           <= '0;
      job_laddr         <= '0;
      res_mse_min_ref   <= '0;
      res_mse_min_value <= '0;
      res_mse_max_ref   <= '0;
      res_mse_max_value <= '0;
      res_status        <= '0;
    end else begin
      state   <= state_n;
      gap_cnt <= (state == POLL_WAIT) ? gap_cnt + GW'(1) : '0;
      if (state == IDLE && cmd_valid) begin
        job_lib    <= cmd_library_size;
        job_bands  <= cmd_pixel_bands;
        job_cap    <= cmd_captured_pixel_addr;
        job_laddr  <= cmd_library_pixel_addr;
        res_status <= '0;
        poll_cnt   <= '0;
      end
      // request is loaded one cycle after entering a bus state, leaving an idle gap
      if (xfer) begin
        reg_req.valid <= 1'b0;
      end else if (bus_st && !reg_req.valid) begin
        reg_req.valid <= 1'b1;
        reg_req.write <= wr_sel;
        reg_req.addr  <= addr_sel;
        reg_req.wdata <= wdata_sel;
        reg_req.wstrb <= '1;
      end
      if (xfer && reg_rsp.error) begin
        res_status[1] <= 1'b1;
      end else if (xfer) begin
        case (state)
          POLL_RD: begin
            poll_cnt <= poll_inc;
            if (reg_rsp.rdata[5])
              res_status[0] <= 1'b1;
            else if (!reg_rsp.rdata[3] && poll_inc == PW'(MAX_POLLS))
              res_status[2] <= 1'b1;
          end
          RD_MAX_REF: res_mse_max_ref   <= reg_rsp.rdata[HSP_LIBRARY_WIDTH-1:0];
          RD_MAX_VAL: res_mse_max_value <= reg_rsp.rdata;
          RD_MIN_REF: res_mse_min_ref   <= reg_rsp.rdata[HSP_LIBRARY_WIDTH-1:0];
          RD_MIN_VAL: res_mse_min_value <= reg_rsp.rdata;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hsid_x_ctrl_seq.sv
// Directed bench for hsid_x_ctrl_seq with a behavioural register-file responder.
module tb_hsid_x_ctrl_seq;
  import hsid_x_reg_pkg::*;
  import hsid_x_ctrl_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_library_size = '0;
  logic [11:0] cmd_pixel_bands = '0;
  logic [31:0] cmd_captured_pixel_addr = '0;
  logic [31:0] cmd_library_pixel_addr = '0;
  reg_req_t    reg_req;
  reg_rsp_t    reg_rsp;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_mse_min_ref, res_mse_max_ref;
  logic [31:0] res_mse_min_value, res_mse_max_value;
  logic [2:0]  res_status;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hsid_x_ctrl_seq #(.POLL_GAP(4), .MAX_POLLS(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_library_size(cmd_library_size), .cmd_pixel_bands(cmd_pixel_bands),
    .cmd_captured_pixel_addr(cmd_captured_pixel_addr),
    .cmd_library_pixel_addr(cmd_library_pixel_addr),
    .reg_req(reg_req), .reg_rsp(reg_rsp),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_mse_min_ref(res_mse_min_ref), .res_mse_min_value(res_mse_min_value),
    .res_mse_max_ref(res_mse_max_ref), .res_mse_max_value(res_mse_max_value),
    .res_status(res_status), .busy(busy)
  );

  // responder configuration (written only by the stimulus process)
  int          wait_n = 0, done_after = 1, err_after = 0;
  logic        err_en = 1'b0;
  logic [7:0]  err_addr = '0;
  logic [31:0] mx_ref = '0, mx_val = '0, mn_ref = '0, mn_val = '0;
  logic        model_clr = 1'b0;

  // responder state (written only by the responder process)
  int          wcnt = 0, stat_rd = 0, n_xfer = 0, start_cnt = 0, clear_cnt = 0;
  int          stab_err = 0, gap_err = 0, wstrb_err = 0;
  logic [31:0] lib_q = '0, bands_q = '0, cap_q = '0, laddr_q = '0;
  logic        last_wr = 1'b0;
  logic [7:0]  last_addr = '0;
  logic [31:0] last_wdata = '0;
  reg_req_t    prev_req = '0;
  logic        pend = 1'b0, done_q = 1'b0;
  logic        done_bit, err_bit;

  assign done_bit = (done_after != 0) && (stat_rd + 1 >= done_after);
  assign err_bit  = (err_after != 0) && (stat_rd + 1 >= err_after);

  always_comb begin
    reg_rsp = '0;
    if (reg_req.valid && wcnt >= wait_n) begin
      reg_rsp.ready = 1'b1;
      reg_rsp.error = err_en && (reg_req.addr == err_addr);
      if (!reg_req.write) begin
        case (reg_req.addr)
          STATUS_OFFSET:        reg_rsp.rdata = 32'h4 | {26'd0, err_bit, 1'b0, done_bit, 3'd0};
          MSE_MAX_REF_OFFSET:   reg_rsp.rdata = mx_ref;
          MSE_MAX_VALUE_OFFSET: reg_rsp.rdata = mx_val;
          MSE_MIN_REF_OFFSET:   reg_rsp.rdata = mn_ref;
          MSE_MIN_VALUE_OFFSET: reg_rsp.rdata = mn_val;
          default:              reg_rsp.rdata = 32'hDEAD_BEEF;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    if (model_clr) begin
      wcnt <= 0; stat_rd <= 0; n_xfer <= 0; start_cnt <= 0; clear_cnt <= 0;
      stab_err <= 0; gap_err <= 0; wstrb_err <= 0; pend <= 1'b0; done_q <= 1'b0;
    end else begin
      if (pend && reg_req != prev_req) stab_err <= stab_err + 1;
      if (done_q && reg_req.valid) gap_err <= gap_err + 1;
      if (reg_req.valid && reg_req.wstrb != 4'hF) wstrb_err <= wstrb_err + 1;
      pend     <= reg_req.valid && !reg_rsp.ready;
      prev_req <= reg_req;
      done_q   <= reg_req.valid && reg_rsp.ready;
      if (!reg_req.valid) wcnt <= 0;
      else if (!reg_rsp.ready) wcnt <= wcnt + 1;
      if (reg_req.valid && reg_rsp.ready) begin
        wcnt       <= 0;
        n_xfer     <= n_xfer + 1;
        last_wr    <= reg_req.write;
        last_addr  <= reg_req.addr;
        last_wdata <= reg_req.wdata;
        if (!reg_rsp.error) begin
          if (reg_req.write) begin
            case (reg_req.addr)
              STATUS_OFFSET: begin
                if (reg_req.wdata[0]) start_cnt <= start_cnt + 1;
                if (reg_req.wdata[4]) clear_cnt <= clear_cnt + 1;
              end
              LIBRARY_SIZE_OFFSET:        lib_q   <= reg_req.wdata;
              PIXEL_BANDS_OFFSET:         bands_q <= reg_req.wdata;
              CAPTURED_PIXEL_ADDR_OFFSET: cap_q   <= reg_req.wdata;
              LIBRARY_PIXEL_ADDR_OFFSET:  laddr_q <= reg_req.wdata;
              default: ;
            endcase
          end else if (reg_req.addr == STATUS_OFFSET) begin
            stat_rd <= stat_rd + 1;
          end
        end
      end
    end
  end

  task automatic run_job(input logic [7:0] lib, input logic [11:0] bands,
                         input logic [31:0] cap, input logic [31:0] laddr,
                         input bit wait_res, output int cyc);
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
    cmd_library_size = lib; cmd_pixel_bands = bands;
    cmd_captured_pixel_addr = cap; cmd_library_pixel_addr = laddr;
    cmd_valid = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 100) begin @(negedge clk); cyc++; end
    if (!cmd_ready) begin nvec++; nerr++; $display("FAIL accept_wait: cmd_ready got 0 want 1"); end
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    if (wait_res) begin
      while (!res_valid && cyc < 3000) begin @(negedge clk); cyc++; end
      nvec++;
      if (!res_valid) begin nerr++; $display("FAIL res_wait: res_valid got 0 want 1"); end
    end
  endtask

  task automatic consume;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL resp_drop: res_valid got %0b want 0", res_valid); end
    nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL resp_ready: cmd_ready got %0b want 1", cmd_ready); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    nvec++; if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready); end
    nvec++; if (reg_req !== '0) begin nerr++; $display("FAIL rst_reg_req: got %h want 0", reg_req); end
    nvec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL rst_valid_busy: got %0b%0b want 00", res_valid, busy); end
    nvec++; if ({res_mse_min_ref, res_mse_max_ref, res_mse_min_value, res_mse_max_value, res_status} !== '0) begin
      nerr++; $display("FAIL rst_results: got nonzero want 0"); end
    rst = 1'b0;
    @(negedge clk);
    nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_ready: got %0b want 1", cmd_ready); end
  endtask

  task automatic test_nominal;
    int cyc;
    done_after = 3; err_after = 0;
    mx_ref = 32'd7; mx_val = 32'hAAAA; mn_ref = 32'd3; mn_val = 32'h5555;
    run_job(8'd10, 12'd5, 32'h1234_5678, 32'h8765_4321, 1'b1, cyc);
    nvec++; if (lib_q !== 32'd10) begin nerr++; $display("FAIL nom_lib: got %h want a", lib_q); end
    nvec++; if (bands_q !== 32'd5) begin nerr++; $display("FAIL nom_bands: got %h want 5", bands_q); end
    nvec++; if (cap_q !== 32'h1234_5678) begin nerr++; $display("FAIL nom_cap: got %h want 12345678", cap_q); end
    nvec++; if (laddr_q !== 32'h8765_4321) begin nerr++; $display("FAIL nom_laddr: got %h want 87654321", laddr_q); end
    nvec++; if (start_cnt !== 1 || clear_cnt !== 1) begin nerr++; $display("FAIL nom_start_clear: got %0d/%0d want 1/1", start_cnt, clear_cnt); end
    nvec++; if (stat_rd !== 3) begin nerr++; $display("FAIL nom_polls: got %0d want 3", stat_rd); end
    nvec++; if (res_status !== 3'b000) begin nerr++; $display("FAIL nom_status: got %b want 000", res_status); end
    nvec++; if (res_mse_max_ref !== 8'd7 || res_mse_max_value !== 32'hAAAA) begin
      nerr++; $display("FAIL nom_max: got %h/%h want 7/aaaa", res_mse_max_ref, res_mse_max_value); end
    nvec++; if (res_mse_min_ref !== 8'd3 || res_mse_min_value !== 32'h5555) begin
      nerr++; $display("FAIL nom_min: got %h/%h want 3/5555", res_mse_min_ref, res_mse_min_value); end
    nvec++; if (cyc !== 34) begin nerr++; $display("FAIL nom_latency: got %0d want 34", cyc); end
    nvec++; if (gap_err !== 0 || wstrb_err !== 0) begin nerr++; $display("FAIL nom_bus_rules: got gap %0d wstrb %0d want 0/0", gap_err, wstrb_err); end
    consume();
  endtask

  task automatic test_trunc;
    int cyc;
    done_after = 1; mx_ref = 32'hFFFF_FFFF;
    run_job(8'hFF, 12'hFFF, 32'h0, 32'h0, 1'b1, cyc);
    nvec++; if (lib_q !== 32'h0000_00FF) begin nerr++; $display("FAIL trunc_lib_wdata: got %h want ff", lib_q); end
    nvec++; if (bands_q !== 32'h0000_0FFF) begin nerr++; $display("FAIL trunc_bands_wdata: got %h want fff", bands_q); end
    nvec++; if (res_mse_max_ref !== 8'hFF) begin nerr++; $display("FAIL trunc_max_ref: got %h want ff", res_mse_max_ref); end
    consume();
  endtask

  task automatic test_hw_error;
    int cyc;
    done_after = 0; err_after = 1;
    mx_ref = 32'd9; mx_val = 32'h1234; mn_ref = 32'd2; mn_val = 32'h42;
    run_job(8'd4, 12'd8, 32'h100, 32'h200, 1'b1, cyc);
    nvec++; if (res_status !== 3'b001) begin nerr++; $display("FAIL hw_status: got %b want 001", res_status); end
    nvec++; if (stat_rd !== 1) begin nerr++; $display("FAIL hw_polls: got %0d want 1", stat_rd); end
    nvec++; if (res_mse_max_ref !== 8'd9 || res_mse_max_value !== 32'h1234 ||
                res_mse_min_ref !== 8'd2 || res_mse_min_value !== 32'h42) begin
      nerr++; $display("FAIL hw_results: got %h/%h/%h/%h want 9/1234/2/42",
                       res_mse_max_ref, res_mse_max_value, res_mse_min_ref, res_mse_min_value); end
    nvec++; if (cyc !== 22) begin nerr++; $display("FAIL hw_latency: got %0d want 22", cyc); end
    consume();
    err_after = 0;
  endtask

  task automatic test_timeout;
    int cyc;
    done_after = 0; err_after = 0; mx_val = 32'h9999;
    run_job(8'd1, 12'd1, 32'h1, 32'h1, 1'b1, cyc);
    nvec++; if (stat_rd !== 4) begin nerr++; $display("FAIL to_polls: got %0d want 4", stat_rd); end
    nvec++; if (last_wr !== 1'b1 || last_addr !== STATUS_OFFSET || last_wdata !== 32'h10) begin
      nerr++; $display("FAIL to_abort: got wr %0b addr %h data %h want 1/0/10", last_wr, last_addr, last_wdata); end
    nvec++; if (clear_cnt !== 2 || n_xfer !== 11) begin nerr++; $display("FAIL to_counts: got clr %0d xfer %0d want 2/11", clear_cnt, n_xfer); end
    nvec++; if (res_status !== 3'b100) begin nerr++; $display("FAIL to_status: got %b want 100", res_status); end
    nvec++; if (res_mse_max_value !== 32'h1234) begin nerr++; $display("FAIL to_keep_results: got %h want 1234", res_mse_max_value); end
    consume();
  endtask

  task automatic test_bus_error;
    int cyc;
    done_after = 1; wait_n = 2; err_en = 1'b1; err_addr = PIXEL_BANDS_OFFSET;
    run_job(8'd3, 12'd3, 32'h3, 32'h3, 1'b1, cyc);
    nvec++; if (res_status !== 3'b010) begin nerr++; $display("FAIL be_status: got %b want 010", res_status); end
    nvec++; if (n_xfer !== 3 || start_cnt !== 0) begin nerr++; $display("FAIL be_xfers: got %0d start %0d want 3/0", n_xfer, start_cnt); end
    nvec++; if (stab_err !== 0) begin nerr++; $display("FAIL be_stable: got %0d unstable cycles want 0", stab_err); end
    repeat (10) @(negedge clk);
    nvec++; if (n_xfer !== 3 || reg_req.valid !== 1'b0) begin
      nerr++; $display("FAIL be_quiet: got xfer %0d valid %0b want 3/0", n_xfer, reg_req.valid); end
    consume();
    wait_n = 0; err_en = 1'b0;
  endtask

  task automatic test_reset_mid_and_backpressure;
    int cyc;
    logic [79:0] snap;
    done_after = 0;
    run_job(8'd6, 12'd6, 32'h6, 32'h6, 1'b0, cyc);
    while (stat_rd < 1 && cyc < 500) begin @(negedge clk); cyc++; end
    nvec++; if (stat_rd < 1) begin nerr++; $display("FAIL mid_reach_poll: got %0d polls want 1", stat_rd); end
    rst = 1'b1;
    @(negedge clk);
    nvec++; if (reg_req.valid !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
      nerr++; $display("FAIL mid_rst: got valid %0b busy %0b res %0b want 000", reg_req.valid, busy, res_valid); end
    rst = 1'b0;
    @(negedge clk);
    nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL mid_rst_idle: cmd_ready got %0b want 1", cmd_ready); end
    done_after = 1; mx_ref = 32'd5; mx_val = 32'hBEEF; mn_ref = 32'd1; mn_val = 32'h11;
    run_job(8'd7, 12'd7, 32'h7, 32'h7, 1'b1, cyc);
    nvec++; if (res_status !== 3'b000 || cyc !== 22) begin
      nerr++; $display("FAIL mid_new_job: got status %b lat %0d want 000/22", res_status, cyc); end
    snap = {res_mse_max_ref, res_mse_max_value, res_mse_min_ref, res_mse_min_value};
    nvec++; if (snap !== {8'd5, 32'hBEEF, 8'd1, 32'h11}) begin nerr++; $display("FAIL bp_values: got %h", snap); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nvec++;
      if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_status !== 3'b000 ||
          {res_mse_max_ref, res_mse_max_value, res_mse_min_ref, res_mse_min_value} !== snap) begin
        nerr++; $display("FAIL bp_hold_%0d: got valid %0b ready %0b want 1/0 with stable results", i, res_valid, cmd_ready); end
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_trunc();
    test_hw_error();
    test_timeout();
    test_bus_error();
    test_reset_mid_and_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
